// File: rtl/fetch.sv
// fetch: cpu32 instruction fetch stage with req/ack imem port, IR latch and branch redirect.
// Define FETCH_FAULT_EN to trap misaligned indirect targets to FAULT_VECTOR.
module fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] FAULT_VECTOR = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [3:0]  ir_opcode,
    output logic [3:0]  ir_opfunc,
    output logic [31:0] ir_pc4,
    input  logic        branch_taken,
    input  logic        branch_ind,
    input  logic [31:0] branch_pc4,
    input  logic [15:0] branch_imm16,
    input  logic [31:0] branch_reg,
    output logic        fetch_fault
);
`ifdef FETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
    state_t state, state_next;
    logic [31:0] pc, req_addr, rel_target, target;
    logic misaligned, fault;
    assign rel_target = branch_pc4 + {{14{branch_imm16[15]}}, branch_imm16, 2'b00};
    assign misaligned = branch_ind && branch_reg[1:0] != 2'b00;
    assign target = !branch_ind ? rel_target :
                    (FAULT_EN && misaligned) ? FAULT_VECTOR : {branch_reg[31:2], 2'b00};
    // DISCARD keeps presenting the squashed request's address until its ack
    assign imem_req    = state == FETCH || state == DISCARD;
    assign imem_addr   = state == DISCARD ? req_addr : pc;
    assign ir_opcode   = ir[31:28];
    assign ir_opfunc   = ir[27:24];
    assign fetch_fault = fault;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = imem_ack ? (branch_taken ? FETCH : HOLD) : (branch_taken ? DISCARD : FETCH);
            HOLD:    state_next = (branch_taken || ir_ready) ? FETCH : HOLD;
            DISCARD: state_next = imem_ack ? FETCH : DISCARD;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            ir       <= '0;
            ir_pc4   <= '0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            fault <= FAULT_EN && branch_taken && misaligned;
            if (state != DISCARD)
                req_addr <= pc;
            if (branch_taken) begin
                pc       <= target;
                ir_valid <= 1'b0;
            end else if (state == FETCH && imem_ack) begin
                ir       <= imem_rdata;
                ir_pc4   <= pc + 32'd4;
                pc       <= pc + 32'd4;
                ir_valid <= 1'b1;
            end else if (state == HOLD && ir_ready) begin
                ir_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed and randomized checks of fetch against a transaction-level reference model.
module tb_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0, ir_valid, ir_ready = 1'b0, fetch_fault;
    logic        branch_taken = 1'b0, branch_ind = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, ir, ir_pc4, branch_pc4 = '0, branch_reg = '0;
    logic [15:0] branch_imm16 = '0;
    logic [3:0]  ir_opcode, ir_opfunc;
    int n_cmp = 0, n_bad = 0;
    // model: a request is live whenever started and no instruction is held
    bit          m_started, m_valid, m_doomed, m_fault;
    logic [31:0] m_pc, m_old, m_ir, m_ir_pc4;

    fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir(ir), .ir_opcode(ir_opcode), .ir_opfunc(ir_opfunc), .ir_pc4(ir_pc4),
        .branch_taken(branch_taken), .branch_ind(branch_ind), .branch_pc4(branch_pc4),
        .branch_imm16(branch_imm16), .branch_reg(branch_reg), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_target(input bit ind, input logic [15:0] imm,
                                               input logic [31:0] pc4, input logic [31:0] rv);
        int off;
        off = int'(signed'(imm)) * 4;
        if (!ind) return pc4 + 32'(off);
`ifdef FETCH_FAULT_EN
        if (rv % 4 != 0) return 32'h10;
`endif
        return rv - rv % 4;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_doomed ? m_old : m_pc;
    endfunction

    task automatic model_reset();
        m_started = 0; m_valid = 0; m_doomed = 0; m_fault = 0;
        m_pc = 32'h0; m_old = 32'h0; m_ir = 32'h0; m_ir_pc4 = 32'h0;
    endtask

    task automatic check_all();
        check("req", {31'b0, imem_req}, {31'b0, m_started && !m_valid});
        check("addr", imem_addr, exp_addr());
        check("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
        check("ir", ir, m_ir);
        check("opcode", {28'b0, ir_opcode}, {28'b0, m_ir[31:28]});
        check("opfunc", {28'b0, ir_opfunc}, {28'b0, m_ir[27:24]});
        check("ir_pc4", ir_pc4, m_ir_pc4);
        check("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    endtask

    task automatic step(input bit a, input bit r, input bit b, input bit i, input logic [15:0] imm,
                        input logic [31:0] pc4, input logic [31:0] rv, input logic [31:0] d);
        logic [31:0] t, ea;
        imem_ack = a; ir_ready = r; branch_taken = b; branch_ind = i;
        branch_imm16 = imm; branch_pc4 = pc4; branch_reg = rv; imem_rdata = d;
        @(posedge clk);
        t = exp_target(i, imm, pc4, rv);
        ea = exp_addr();
`ifdef FETCH_FAULT_EN
        m_fault = b && i && (rv % 4 != 0);
`else
        m_fault = 0;
`endif
        if (!m_started) begin
            m_started = 1;
            if (b) m_pc = t;
        end else if (!m_valid) begin
            if (a && !m_doomed && !b) begin
                m_ir = d; m_ir_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
            end else if (b) m_pc = t;
            if (a) m_doomed = 0;
            else if (b && !m_doomed) begin m_doomed = 1; m_old = ea; end
        end else if (b) begin
            m_valid = 0; m_pc = t;
        end else if (r) m_valid = 0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit a, input bit r);
        step(a, r, 0, 0, 16'h0, 32'h0, 32'h0, 32'h1000_0000 | exp_addr());
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check_all();
        @(negedge clk); rst_n = 1'b1;
        // zero-wait stream: 0, 4, 8
        for (int k = 0; k < 7; k++) idle(1, 1);
        check("stream_pc4", ir_pc4, 32'd12);
        // wait states, then ready held low in HOLD
        for (int k = 0; k < 4; k++) idle(0, 1);
        idle(1, 0);
        for (int k = 0; k < 5; k++) idle(1, 0);
        check("hold_noreq", {31'b0, imem_req}, 32'h0);
        idle(1, 1);
        // relative branch in HOLD with simultaneous ready
        idle(1, 0);
        step(0, 1, 1, 0, 16'hFFFF, 32'h100, 32'h0, 32'h0);
        check("rel_addr", imem_addr, 32'hFC);
        check("rel_flush", {31'b0, ir_valid}, 32'h0);
        // indirect redirect while the request to FC is outstanding
        idle(0, 0);
        step(0, 0, 1, 1, 16'h0, 32'h0, 32'h200, 32'h0);
        check("disc_hold", imem_addr, 32'hFC);
        idle(0, 0);
        idle(1, 0);
        check("disc_target", imem_addr, 32'h200);
        check("disc_drop", {31'b0, ir_valid}, 32'h0);
        // misaligned indirect target from HOLD
        idle(1, 0);
        step(0, 0, 1, 1, 16'h0, 32'h0, 32'h203, 32'h0);
`ifdef FETCH_FAULT_EN
        check("mis_addr", imem_addr, 32'h10);
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
`else
        check("mis_addr", imem_addr, 32'h200);
        check("mis_fault", {31'b0, fetch_fault}, 32'h0);
`endif
        idle(0, 0);
        check("fault_pulse", {31'b0, fetch_fault}, 32'h0);
        // pc wrap
        idle(1, 0);
        step(0, 0, 1, 1, 16'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        idle(1, 1);
        idle(0, 1);
        check("wrap", imem_addr, 32'h0);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] rv;
            rv = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, 16'($urandom), $urandom & 32'hFFFF_FFFC, rv, $urandom);
        end
        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_req", {31'b0, imem_req}, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'b0, ir_valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 6; k++) idle(1, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the cpu32 core. Holds the program counter, issues one word-aligned request at a time to instruction memory over a req/ack handshake, and latches the returned word into an instruction register. The decoder reads the opcode and function fields from that register. The execute stage redirects fetch when a branch is taken, using either a PC-relative or a register-indirect target. Wrong-path fetches are squashed, including a request that is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h00000000: address of the first fetch after reset.
- FAULT_VECTOR, 32'h00000010: redirect address for a misaligned indirect target; used only when FETCH_FAULT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; bits [1:0] are always 0.
- imem_ack  in  1  request complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- ir_valid  out  1  the instruction register holds an unconsumed instruction.
- ir_ready  in  1  downstream accepts the instruction register this cycle.
- ir  out  32  instruction register.
- ir_opcode  out  4  ir[31:28]; feeds the decoder opcode input.
- ir_opfunc  out  4  ir[27:24]; feeds the decoder opfunc input.
- ir_pc4  out  32  address of the instruction in ir, plus 4.
- branch_taken  in  1  redirect request from execute.
- branch_ind  in  1  target select: 0 = relative, 1 = indirect.
- branch_pc4  in  32  pc+4 of the branch instruction.
- branch_imm16  in  16  relative offset, in words, signed.
- branch_reg  in  32  indirect target, from Rb.
- fetch_fault  out  1  one-cycle pulse on a misaligned indirect target.

## Operation
- The state machine has four states: IDLE, FETCH, HOLD and DISCARD. Reset places it in IDLE.
- IDLE → FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - On imem_ack: ir ← imem_rdata, ir_pc4 ← pc+4, pc ← pc+4, ir_valid ← 1, next state HOLD.
- HOLD:
  - imem_req = 0.
  - If ir_valid & ir_ready: ir_valid ← 0, next state FETCH.
- DISCARD:
  - imem_req = 1 and imem_addr = the old address, held until ack.
  - On imem_ack the data is dropped; next state FETCH with the already-updated pc.
- Redirect target:
  - Relative: branch_pc4 + {sext(branch_imm16), 2'b00}, with 32-bit wrap-around.
  - Indirect: branch_reg.
- Redirect takes priority over every other event in the same cycle:
  - pc ← target.
  - ir_valid ← 0. This flushes any held instruction, even if ir_ready is high in the same cycle.
  - If the state is FETCH without ack, or DISCARD without ack: next state DISCARD.
  - If the state is FETCH with ack: the returned data is dropped; next state FETCH.
  - If the state is HOLD: next state FETCH.
  - If the state is DISCARD with ack: next state FETCH.
  - A second redirect while in DISCARD overwrites pc; the latest target wins.
- Handshake rule: once imem_req is asserted, imem_req and imem_addr stay stable until imem_ack is sampled high. At most one request is outstanding.
- pc increments wrap: 32'hFFFFFFFC + 4 = 0.

## Timing
- Reset values: imem_req 0; imem_addr RESET_PC; ir_valid 0; ir 0; ir_pc4 0; fetch_fault 0; pc RESET_PC.
- Reset mid-request: the in-flight request is abandoned. The memory side must tolerate an imem_req drop on reset.
- imem_req and imem_addr are registered-state decodes with no combinational path from inputs.
- A zero-wait memory acks in the same cycle as the request.
- ir_valid rises in the cycle after ack.
- Best-case throughput is one instruction per 2 cycles (FETCH, HOLD).
- A redirect seen at edge N puts the target on imem_addr in cycle N+1, unless the state is DISCARD, where the target waits for the outstanding ack.
- ir_ready is ignored when ir_valid = 0.

## Configuration
- FETCH_FAULT_EN defined:
  - An indirect target with [1:0] ≠ 0 sets pc ← FAULT_VECTOR.
  - fetch_fault pulses high for exactly the cycle after the redirect edge.
- FETCH_FAULT_EN undefined:
  - Target bits [1:0] are forced to 0 and execution continues silently.
  - fetch_fault is tied to 0.
- Relative targets are always aligned by construction.

## Test plan
- Reset release, zero-wait memory returning 32'h1000_0000 | addr: the imem_addr sequence is 0, 4, 8, one request every 2 cycles; ir_pc4 = 4, 8, 12.
- Three wait cycles before ack: imem_req and imem_addr stay constant for 4 cycles; ir updates only after the ack edge.
- ir_ready held low for 5 cycles in HOLD: no new request is issued and ir is stable. When ir_ready rises, the next request appears one cycle later.
- Relative branch with branch_pc4 = 32'h100 and imm16 = 16'hFFFF while in HOLD: ir_valid drops and the next imem_addr = 32'hFC. Same test with simultaneous ir_ready: branch wins.
- Indirect branch to 32'h200 while a request to 32'h40 is waiting: 32'h40 is held until ack, its data is never loaded into ir, and the next request goes to 32'h200.
- Indirect target 32'h203: with FETCH_FAULT_EN, the next request goes to 32'h10 and fetch_fault is high for 1 cycle. Without it, the next request goes to 32'h200 and fetch_fault stays 0.
